// File: rtl/seven_segment_decoder_if.sv
// Bundles the request/response signals of the seven-segment image decoder.
// master drives a request and reads the result; slave is the decoder side.
interface seven_segment_decoder_if;
    logic        start;
    logic [4:0]  radix;
    logic [55:0] segs;
    logic        busy;
    logic        done;
    logic [31:0] num;
    logic        err;

    modport master (output start, radix, segs, input busy, done, num, err);
    modport slave  (input start, radix, segs, output busy, done, num, err);
endinterface

// File: rtl/seven_segment_decoder.sv
// Rebuilds a signed 32-bit value from a seven-digit seven-segment display image,
// one digit per clock (most significant first), then applies the active-low sign.
module seven_segment_decoder (
    input  logic                   clk,
    input  logic                   rst_n,
    seven_segment_decoder_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [49:0] segs_q, segs_d;
    logic [4:0]  radix_q, radix_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  k_q, k_d;
    logic        flag_q, flag_d;
    logic [31:0] num_q, num_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic [6:0]  pat;
    logic        dig_ok;
    logic [3:0]  dig_val;
    logic        unused_hi;

    assign unused_hi = ^bus.segs[55:50];

    always_comb begin
        case (k_q)
            3'd7:    pat = segs_q[48:42];
            3'd6:    pat = segs_q[41:35];
            3'd5:    pat = segs_q[34:28];
            3'd4:    pat = segs_q[27:21];
            3'd3:    pat = segs_q[20:14];
            3'd2:    pat = segs_q[13:7];
            3'd1:    pat = segs_q[6:0];
            default: pat = '1;
        endcase
    end

    // Exact-match decode; an unknown pattern contributes 0 and is flagged.
    always_comb begin
        dig_ok  = 1'b1;
        dig_val = 4'h0;
        case (pat)
            7'b0000001: dig_val = 4'h0;
            7'b1001111: dig_val = 4'h1;
            7'b0010010: dig_val = 4'h2;
            7'b0000110: dig_val = 4'h3;
            7'b1001100: dig_val = 4'h4;
            7'b0100100: dig_val = 4'h5;
            7'b0100000: dig_val = 4'h6;
            7'b0001111: dig_val = 4'h7;
            7'b0000000: dig_val = 4'h8;
            7'b0000100: dig_val = 4'h9;
            7'b0001000: dig_val = 4'hA;
            7'b1100000: dig_val = 4'hB;
            7'b1110010: dig_val = 4'hC;
            7'b1000010: dig_val = 4'hD;
            7'b0110000: dig_val = 4'hE;
            7'b0111000: dig_val = 4'hF;
            default: begin
                dig_ok  = 1'b0;
                dig_val = 4'h0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        segs_d  = segs_q;
        radix_d = radix_q;
        acc_d   = acc_q;
        k_d     = k_q;
        flag_d  = flag_q;
        num_d   = num_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    segs_d  = bus.segs[49:0];
                    radix_d = bus.radix;
                    acc_d   = '0;
                    flag_d  = (bus.radix < 5'd2) || (bus.radix > 5'd16);
                    k_d     = 3'd7;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                acc_d  = acc_q * {27'd0, radix_q} + {28'd0, dig_val};
                flag_d = flag_q | ~dig_ok | ({1'b0, dig_val} >= radix_q);
                k_d    = k_q - 3'd1;
                if (k_q == 3'd1) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                if (flag_q) begin
                    num_d = '0;
                end else if (!segs_q[49]) begin
                    num_d = -acc_q;
                end else begin
                    num_d = acc_q;
                end
                err_d   = flag_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            segs_q  <= '0;
            radix_q <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            flag_q  <= 1'b0;
            num_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            segs_q  <= segs_d;
            radix_q <= radix_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            flag_q  <= flag_d;
            num_q   <= num_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.num  = num_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed-vector bench: the driver queues hand-computed results, a negedge
// monitor checks each done pulse for value, error flag and 8-clock latency.
module tb_seven_segment_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_decoder_if bus ();

    seven_segment_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111;
    localparam logic [6:0] P9 = 7'b0000100, PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b1100000, PC = 7'b1110010, PD = 7'b1000010, PE = 7'b0110000;
    localparam logic [6:0] PF = 7'b0111000, PBL = 7'b1111111;

    typedef struct packed {
        logic [31:0] num;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;
    logic       busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [55:0] mk(input logic sgn, input logic [6:0] d7, d6, d5, d4,
                                       d3, d2, d1);
        return {6'h3F, sgn, d7, d6, d5, d4, d3, d2, d1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: record accepted starts, check every done against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
        end else begin
            if (bus.busy && !busy_prev) acc_q.push_back(cyc);
            if (bus.done) begin
                check("busy_with_done", {31'd0, bus.busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_done: got num=%h, expected no done", bus.num);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("num", bus.num, e.num);
                    check("err", {31'd0, bus.err}, {31'd0, e.err});
                    if (acc_q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL latency: got done with no accepted start, expected 8");
                    end else begin
                        check("latency", 32'(cyc - acc_q.pop_front()), 32'd8);
                    end
                end
            end
        end
        busy_prev = bus.busy;
    end

    task automatic issue(input logic [55:0] img, input logic [4:0] rdx,
                         input logic [31:0] enum_, input logic eerr);
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.segs  = img;
        bus.radix = rdx;
        exp_q.push_back('{num: enum_, err: eerr});
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        logic pb;
        bus.start = 1'b0;
        bus.segs  = '0;
        bus.radix = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_num", bus.num, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);

        issue(mk(1'b1, P0, P0, P1, P2, P3, P4, P5), 5'd10, 32'd12345, 1'b0);
        repeat (10) @(posedge clk);
        issue(mk(1'b0, P0, P0, P0, P0, P0, PF, PF), 5'd16, 32'hFFFFFF01, 1'b0);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, P0, P0, P0, P0, P0, P0, PA), 5'd10, 32'd0, 1'b1);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, P1, P2, P3, PBL, P5, P6, P7), 5'd16, 32'd0, 1'b1);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, P0, P0, P0, P0, P0, P0, P1), 5'd1, 32'd0, 1'b1);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, P1, P1, P1, P1, P1, P1, P1), 5'd2, 32'd127, 1'b0);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, P1, P1, P1, P1, P1, P1, P1), 5'd16, 32'h01111111, 1'b0);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, PF, PE, PD, PC, PB, PA, P9), 5'd16, 32'h0FEDCBA9, 1'b0);
        repeat (10) @(posedge clk);
        issue(mk(1'b0, P0, P0, P0, P0, P0, P0, P0), 5'd10, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        issue(mk(1'b1, P0, P0, P0, P0, P0, P0, P1), 5'd17, 32'd0, 1'b1);
        repeat (10) @(posedge clk);

        // Second start mid-conversion and input changes must not disturb the first.
        issue(mk(1'b1, P0, P0, P0, P0, P0, P4, P2), 5'd10, 32'd42, 1'b0);
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.segs  = mk(1'b0, P9, P9, P9, P9, P9, P9, P9);
        bus.radix = 5'd16;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.radix = 5'd0;
        repeat (12) @(posedge clk);

        // Reset during SCAN discards the conversion.
        issue(mk(1'b1, P0, P0, P0, P0, P0, P0, P7), 5'd10, 32'd7, 1'b0);
        void'(exp_q.pop_back());
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_num", bus.num, 32'd0);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk); #1;
        check("postrst_num", bus.num, 32'd0);
        check("postrst_busy", {31'd0, bus.busy}, 32'd0);

        // Held start: four back-to-back conversions.
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.segs  = mk(1'b0, P0, P0, P0, P0, P3, P2, P1);
        bus.radix = 5'd10;
        n  = 0;
        pb = bus.busy;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(posedge clk); #2;
            if (bus.busy && !pb) begin
                n++;
                exp_q.push_back('{num: 32'hFFFFFEBF, err: 1'b0});
            end
            pb = bus.busy;
        end
        bus.start = 1'b0;
        check("held_accepts", 32'(n), 32'd4);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL missing_done: got no done, expected num=%h err=%b", e.num, e.err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
